// File: rtl/sprite_plotter.sv
// sprite_plotter
//   Moves a small bitmap sprite on a 160x120 framebuffer driven through a
//   vga_adapter-style pixel port. Each accepted request erases the sprite at
//   its previous position (painting BG_COLOUR under its opaque pixels), then
//   draws it at the new position, one pixel per clock, row-major.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high
//   req_valid  : request strobe, accepted when req_ready is high
//   req_ready  : high only while idle
//   req_x/y    : new top-left corner (x 0..159, y 0..119)
//   req_colour : sprite colour
//   req_mask   : bitmap, bit dy*SPRITE_W+dx, 1 = opaque
//   x/y/colour : registered pixel coordinates and colour
//   write      : registered pixel write strobe
//   done       : one-cycle pulse when a request completes
module sprite_plotter #(
  parameter int          SPRITE_W  = 5,
  parameter int          SPRITE_H  = 5,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [7:0]                   req_x,
  input  logic [6:0]                   req_y,
  input  logic [2:0]                   req_colour,
  input  logic [SPRITE_W*SPRITE_H-1:0] req_mask,
  output logic [7:0]                   x,
  output logic [6:0]                   y,
  output logic [2:0]                   colour,
  output logic                         write,
  output logic                         done
);

  localparam int N = SPRITE_W * SPRITE_H;
  localparam logic [3:0] LAST_DX = 4'(SPRITE_W - 1);
  localparam logic [3:0] LAST_DY = 4'(SPRITE_H - 1);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     dx_q, dx_d, dy_q, dy_d;
  logic           has_prev_q, has_prev_d;
  logic [7:0]     new_x_q, new_x_d, prev_x_q, prev_x_d;
  logic [6:0]     new_y_q, new_y_d, prev_y_q, prev_y_d;
  logic [2:0]     new_colour_q, new_colour_d;
  logic [N-1:0]   new_mask_q, new_mask_d, prev_mask_q, prev_mask_d;
  logic [7:0]     x_q, x_d;
  logic [6:0]     y_q, y_d;
  logic [2:0]     colour_q, colour_d;
  logic           write_q, write_d, done_q, done_d;

  // Scan datapath signals
  logic [7:0]     base_x;
  logic [6:0]     base_y;
  logic [N-1:0]   sel_mask, bit_sel;
  logic [7:0]     idx;
  logic [8:0]     px;
  logic [7:0]     py;
  logic           pix_on, on_screen, last_pix;

  always_comb begin
    // Erase walks the old footprint, draw walks the latched new one.
    base_x   = (state_q == ERASE) ? prev_x_q    : new_x_q;
    base_y   = (state_q == ERASE) ? prev_y_q    : new_y_q;
    sel_mask = (state_q == ERASE) ? prev_mask_q : new_mask_q;

    idx      = 8'(dy_q) * 8'(SPRITE_W) + 8'(dx_q);
    bit_sel  = '0;
    bit_sel[0] = 1'b1;
    bit_sel  = bit_sel << idx;
    pix_on   = |(sel_mask & bit_sel);

    // Widened sums so off-screen pixels are clipped instead of wrapping.
    px        = {1'b0, base_x} + {5'b0, dx_q};
    py        = {1'b0, base_y} + {4'b0, dy_q};
    on_screen = (px < 9'd160) && (py < 8'd120);
    last_pix  = (dx_q == LAST_DX) && (dy_q == LAST_DY);
  end

  assign req_ready = (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    has_prev_d   = has_prev_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    new_colour_d = new_colour_q;
    new_mask_d   = new_mask_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    prev_mask_d  = prev_mask_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    write_d      = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          new_x_d      = req_x;
          new_y_d      = req_y;
          new_colour_d = req_colour;
          new_mask_d   = req_mask;
          dx_d         = '0;
          dy_d         = '0;
          state_d      = has_prev_q ? ERASE : DRAW;
        end
      end

      ERASE, DRAW: begin
        x_d      = px[7:0];
        y_d      = py[6:0];
        colour_d = (state_q == ERASE) ? BG_COLOUR : new_colour_q;
        write_d  = pix_on && on_screen;

        if (dx_q == LAST_DX) begin
          dx_d = '0;
          dy_d = (dy_q == LAST_DY) ? 4'd0 : dy_q + 4'd1;
        end else begin
          dx_d = dx_q + 4'd1;
        end

        if (last_pix) begin
          state_d = (state_q == ERASE) ? DRAW : DONE;
        end
      end

      DONE: begin
        done_d      = 1'b1;
        prev_x_d    = new_x_q;
        prev_y_d    = new_y_q;
        prev_mask_d = new_mask_q;
        has_prev_d  = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dx_q         <= '0;
      dy_q         <= '0;
      has_prev_q   <= 1'b0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      new_colour_q <= '0;
      new_mask_q   <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_mask_q  <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      write_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      has_prev_q   <= has_prev_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      new_colour_q <= new_colour_d;
      new_mask_q   <= new_mask_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      prev_mask_q  <= prev_mask_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      write_q      <= write_d;
      done_q       <= done_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign write  = write_q;
  assign done   = done_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter with the default 5x5 sprite.
module tb_sprite_plotter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_x;
  logic [6:0]  req_y;
  logic [2:0]  req_colour;
  logic [24:0] req_mask;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        write;
  logic        done;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int nwr;
  int ndone;

  sprite_plotter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_mask(req_mask),
    .x(x), .y(y), .colour(colour), .write(write), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference pixel for step k of a 5x5 scan at base (bx,by).
  function automatic logic exp_wr(input int bx, input int by, input logic [24:0] m, input int k);
    int ex, ey;
    ex = bx + (k % 5);
    ey = by + (k / 5);
    return m[k] && (ex < 160) && (ey < 120);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_write", 32'(write), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_colour", 32'(colour), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 1);
  endtask

  task automatic send(input logic [7:0] sx, input logic [6:0] sy, input logic [2:0] sc,
                      input logic [24:0] sm, input logic hold);
    int i;
    for (i = 0; i < 200 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("ready_timeout", 0, 1);
    req_x = sx; req_y = sy; req_colour = sc; req_mask = sm;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (hold) begin
      // Different request kept valid while busy: must be ignored.
      req_x = 8'd100; req_y = 7'd5; req_colour = 3'b001; req_mask = 25'h0;
    end else begin
      req_valid = 1'b0;
      req_x = 8'hxx; req_y = 7'hxx; req_colour = 3'hx; req_mask = 'x;
    end
  endtask

  // Checks cycles 1..max_cyc after acceptance; full op ends with done at total+1.
  task automatic expect_op(input logic er, input int px, input int py, input logic [24:0] pm,
                           input int nx, input int ny, input logic [2:0] nc, input logic [24:0] nm,
                           input int max_cyc, output int writes);
    int total, bx, by, k;
    logic [24:0] m;
    logic [2:0] ec;
    logic ew;
    total  = er ? 50 : 25;
    writes = 0;
    for (int c = 1; c <= max_cyc && c <= total + 1; c++) begin
      @(posedge clk);
      #1;
      if (write) writes++;
      if (c == total + 1) begin
        chk("done_pulse", 32'(done), 1);
        chk("write_in_done", 32'(write), 0);
      end else begin
        if (er && c <= 25) begin
          bx = px; by = py; m = pm; ec = 3'b000; k = c - 1;
        end else begin
          bx = nx; by = ny; m = nm; ec = nc; k = er ? c - 26 : c - 1;
        end
        ew = exp_wr(bx, by, m, k);
        chk($sformatf("done_early_c%0d", c), 32'(done), 0);
        chk($sformatf("write_c%0d", c), 32'(write), 32'(ew));
        if (ew) begin
          chk($sformatf("x_c%0d", c), 32'(x), 32'(bx + k % 5));
          chk($sformatf("y_c%0d", c), 32'(y), 32'(by + k / 5));
          chk($sformatf("colour_c%0d", c), 32'(colour), 32'(ec));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_x = '0; req_y = '0; req_colour = '0; req_mask = '0;

    // Reset state and readiness.
    do_reset();

    // First sprite: draw only, done at cycle 26.
    send(8'd10, 7'd20, 3'b110, 25'h1FF_FFFF, 1'b0);
    expect_op(1'b0, 0, 0, 25'h0, 10, 20, 3'b110, 25'h1FF_FFFF, 100, nwr);
    chk("a_writes", 32'(nwr), 25);

    // Move right by one: erase then draw, done at cycle 51.
    send(8'd11, 7'd20, 3'b110, 25'h1FF_FFFF, 1'b0);
    expect_op(1'b1, 10, 20, 25'h1FF_FFFF, 11, 20, 3'b110, 25'h1FF_FFFF, 100, nwr);
    chk("b_writes", 32'(nwr), 50);

    // Corner clipping after a fresh reset: 6 visible pixels.
    do_reset();
    send(8'd157, 7'd118, 3'b010, 25'h1FF_FFFF, 1'b0);
    expect_op(1'b0, 0, 0, 25'h0, 157, 118, 3'b010, 25'h1FF_FFFF, 100, nwr);
    chk("clip_writes", 32'(nwr), 6);

    // Sparse mask: only the two diagonal corners.
    do_reset();
    send(8'd50, 7'd60, 3'b101, 25'h100_0001, 1'b0);
    expect_op(1'b0, 0, 0, 25'h0, 50, 60, 3'b101, 25'h100_0001, 100, nwr);
    chk("sparse_writes", 32'(nwr), 2);

    // Busy requests ignored, then reset during draw cycle 10.
    do_reset();
    send(8'd20, 7'd30, 3'b011, 25'h1FF_FFFF, 1'b1);
    expect_op(1'b0, 0, 0, 25'h0, 20, 30, 3'b011, 25'h1FF_FFFF, 9, nwr);
    chk("busy_writes", 32'(nwr), 9);
    @(posedge clk);
    #3;
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("abort_write", 32'(write), 0);
    chk("abort_x", 32'(x), 0);
    chk("abort_y", 32'(y), 0);
    chk("abort_colour", 32'(colour), 0);
    chk("abort_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 0);

    // After the abort there is no previous sprite: draw only.
    send(8'd40, 7'd40, 3'b111, 25'h0AA_AAAA, 1'b0);
    expect_op(1'b0, 0, 0, 25'h0, 40, 40, 3'b111, 25'h0AA_AAAA, 100, nwr);
    chk("post_abort_writes", 32'(nwr), 12);

    // Same position again still erases fully before drawing.
    send(8'd40, 7'd40, 3'b100, 25'h1FF_FFFF, 1'b0);
    expect_op(1'b1, 40, 40, 25'h0AA_AAAA, 40, 40, 3'b100, 25'h1FF_FFFF, 100, nwr);
    chk("same_pos_writes", 32'(nwr), 37);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sprite_plotter.md
SPRITE_PLOTTER -- requirements
Module: sprite_plotter

Interface
REQ-001 The module SHALL have parameter SPRITE_W, default 5: sprite width in pixels, range 1..16.
REQ-002 The module SHALL have parameter SPRITE_H, default 5: sprite height in pixels, range 1..16.
REQ-003 The module SHALL have parameter BG_COLOUR, default 3'b000: colour written when erasing.
REQ-004 The module SHALL have these ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  move/draw request.
- req_ready  output  1  high when a request can be accepted.
- req_x  input  8  new sprite top-left x (0..159).
- req_y  input  7  new sprite top-left y (0..119).
- req_colour  input  3  sprite colour.
- req_mask  input  SPRITE_W*SPRITE_H  sprite bitmap; bit index dy*SPRITE_W+dx; 1 = opaque.
- x  output  8  pixel x to vga_adapter.
- y  output  7  pixel y to vga_adapter.
- colour  output  3  pixel colour to vga_adapter.
- write  output  1  pixel write strobe to vga_adapter.
- done  output  1  one-cycle pulse when a request completes.

Function
REQ-005 The module SHALL implement the FSM states IDLE, ERASE, DRAW and DONE.
REQ-006 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1.
REQ-007 On acceptance, the module SHALL latch req_x, req_y, req_colour and req_mask, clear the scan counters dx and dy, and go to ERASE if has_prev=1, else to DRAW.
REQ-008 ERASE SHALL scan the previous position row-major (dx inner 0..SPRITE_W-1, dy outer 0..SPRITE_H-1), one pixel per cycle, SPRITE_W*SPRITE_H cycles total.
- write=1 with colour=BG_COLOUR where the previous mask bit is 1.
- write=0 where the previous mask bit is 0.
REQ-009 After the last ERASE pixel, the module SHALL clear dx and dy and go to DRAW.
REQ-010 DRAW SHALL scan the latched new position in the same order and cycle count.
- write=1 with colour=latched colour where the new mask bit is 1.
- write=0 otherwise.
REQ-011 After the last DRAW pixel, the module SHALL go to DONE.
REQ-012 In DONE the module SHALL, for exactly one cycle:
- assert done;
- copy the new position and mask into the previous-sprite registers;
- set has_prev=1;
- return to IDLE.
REQ-013 Pixel coordinates SHALL be computed as base+dx and base+dy at 9-bit and 8-bit width respectively.
REQ-014 A pixel with computed x>=160 or y>=120 SHALL be clipped: write=0, with the scan counters still advancing (no wrap-around onto the opposite screen edge).
REQ-015 x, y, colour and write SHALL be registered outputs; the first pixel SHALL appear the cycle after acceptance.
REQ-016 Latency from the acceptance edge SHALL be:
- without has_prev: done at cycle N+1, where N=SPRITE_W*SPRITE_H;
- with has_prev: done at cycle 2N+1.
REQ-017 In IDLE and DONE, write SHALL be 0.
REQ-018 req_valid and request inputs SHALL be ignored while not in IDLE; they need not be held after acceptance.
REQ-019 A request with the same position as the previous sprite SHALL still perform a full erase followed by a full draw.

Reset
REQ-020 Asserting reset SHALL asynchronously force:
- state=IDLE, has_prev=0, dx=dy=0;
- x=0, y=0, colour=0, write=0, done=0;
- all latched and previous-sprite registers to 0.
REQ-021 Reset asserted mid-ERASE or mid-DRAW SHALL abort the operation with no done pulse; the next request SHALL draw only, with no erase.
REQ-022 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-023 Reset release, request x=10, y=20, colour=3'b110, all-ones mask -> 25 writes covering (10..14, 20..24) in row-major order with colour 110, done at cycle 26, no erase.
REQ-024 Follow-up request x=11, y=20 -> 25 writes of colour 000 at (10..14, 20..24), then 25 writes of colour 110 at (11..15, 20..24), done at cycle 51.
REQ-025 Request x=157, y=118 -> writes only for x 157..159 and y 118..119 (6 writes); done still at cycle 26; no writes at x<157 or y<118.
REQ-026 Mask with only bit 0 and bit 24 set -> write=1 only at (x, y) and (x+4, y+4); 23 cycles with write=0.
REQ-027 req_valid held high during DRAW -> the request is ignored until IDLE; reset asserted at draw cycle 10 -> outputs are 0 immediately, no done pulse, and the next request performs no erase.
